// File: rtl/nibble_rx_pkg.sv
// nibble_rx_pkg
// Shared types and constants for the nibble receiver slice.
//   state_e     : pairing FSM state (LO_WAIT / HI_WAIT)
//   NIB_W/BYTE_W: nibble and byte widths
//   CNT_W       : width of the pairing timeout counter
//   DEFAULT_*   : default parameter values for the receiver and its FIFO
package nibble_rx_pkg;

  localparam int NIB_W               = 4;
  localparam int BYTE_W              = 8;
  localparam int CNT_W               = 8;
  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_TIMEOUT     = 255;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    LO_WAIT = 1'b0,
    HI_WAIT = 1'b1
  } state_e;

  // Bytes are assembled low nibble first, so the later nibble lands in the top half.
  function automatic logic [BYTE_W-1:0] pack_byte(input logic [NIB_W-1:0] lo,
                                                  input logic [NIB_W-1:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/nibble_rx_if.sv
// nibble_rx_if
// Bundles the host nibble pins and the core-side byte handshake.
//   d_in/stb      : host nibble and asynchronous strobe
//   data_out/valid: FIFO head byte and non-empty indication
//   rd            : core pop request
//   ovf/terr      : sticky overflow / pairing-timeout flags
//   clr_err       : clears both sticky flags
// master = environment driving the pins, slave = the receiver.
interface nibble_rx_if;
  import nibble_rx_pkg::*;

  logic [NIB_W-1:0]  d_in;
  logic              stb;
  logic [BYTE_W-1:0] data_out;
  logic              valid;
  logic              rd;
  logic              ovf;
  logic              terr;
  logic              clr_err;

  modport master (
    output d_in, stb, rd, clr_err,
    input  data_out, valid, ovf, terr
  );

  modport slave (
    input  d_in, stb, rd, clr_err,
    output data_out, valid, ovf, terr
  );

endinterface

// File: rtl/nibble_rx_byte_fifo.sv
// byte_fifo
// First-word-fall-through FIFO; the head entry is always visible on dout_o.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write din_i (accepted when not full, or when popping in the same cycle)
//   din_i      : write data
//   pop_i      : remove the head entry (ignored while empty)
//   dout_o     : head entry
//   empty_o    : no entries held
//   full_o     : DEPTH entries held
module byte_fifo
  import nibble_rx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal means empty, equal except the MSB means full.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // Storage is reset so the head reads 0x00 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/nibble_rx.sv
// nibble_rx
// Receives host nibbles qualified by an asynchronous strobe, pairs them
// low-nibble-first into bytes and queues the bytes in a FWFT FIFO.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : nibble_rx_if.slave (host pins, byte handshake, sticky flags)
module nibble_rx
  import nibble_rx_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  nibble_rx_if.slave    bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0]            stb_sync_q;
  logic [SYNC_STAGES-1:0][NIB_W-1:0] d_sync_q;
  logic                              stb_hist_q;
  logic                              stb_s;
  logic [NIB_W-1:0]                  d_s;
  logic                              stb_rise;

  state_e             state_q;
  logic [NIB_W-1:0]   lo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               push_q;
  logic [BYTE_W-1:0]  byte_q;
  logic               terr_q;
  logic               ovf_q;

  logic               terr_set;
  logic               ovf_set;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [BYTE_W-1:0]  fifo_dout;

  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign d_s      = d_sync_q[SYNC_STAGES-1];
  assign stb_rise = stb_s && !stb_hist_q;

  // Strobe and data share the same synchroniser depth so the nibble is settled when the edge is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_sync_q <= '0;
      d_sync_q   <= '0;
      stb_hist_q <= 1'b0;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], bus.stb};
      d_sync_q   <= {d_sync_q[SYNC_STAGES-2:0], bus.d_in};
      stb_hist_q <= stb_s;
    end
  end

  // Expiry is checked before the strobe: a strobe landing on the expiry cycle starts a new byte.
  assign terr_set = (state_q == HI_WAIT) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LO_WAIT;
      lo_q    <= '0;
      cnt_q   <= '0;
      push_q  <= 1'b0;
      byte_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (terr_set)         terr_q <= 1'b1;
      else if (bus.clr_err) terr_q <= 1'b0;
      case (state_q)
        LO_WAIT: begin
          if (stb_rise) begin
            lo_q    <= d_s;
            cnt_q   <= TIMEOUT_LD;
            state_q <= HI_WAIT;
          end
        end
        HI_WAIT: begin
          if (cnt_q == '0) begin
            if (stb_rise) begin
              lo_q  <= d_s;
              cnt_q <= TIMEOUT_LD;
            end else begin
              state_q <= LO_WAIT;
            end
          end else if (stb_rise) begin
            byte_q  <= pack_byte(lo_q, d_s);
            push_q  <= 1'b1;
            state_q <= LO_WAIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= LO_WAIT;
      endcase
    end
  end

  assign pop     = bus.rd && !fifo_empty;
  assign ovf_set = push_q && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ovf_q <= 1'b0;
    else if (ovf_set)     ovf_q <= 1'b1;
    else if (bus.clr_err) ovf_q <= 1'b0;
  end

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .din_i   (byte_q),
    .pop_i   (bus.rd),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.data_out = fifo_dout;
  assign bus.valid    = !fifo_empty;
  assign bus.ovf      = ovf_q;
  assign bus.terr     = terr_q;

endmodule

// File: doc/nibble_rx.md
# nibble_rx

Input-side counterpart to the chip's 4-bit output port. It receives nibbles that an external host drives onto the input pins with an asynchronous strobe. It synchronises them into the core clock domain, pairs them low-nibble-first into bytes, and buffers the bytes in a small first-word-fall-through FIFO. The core pops bytes with a simple valid/read handshake; overflow and nibble-pairing timeouts are reported as sticky flags.

## Interface
Parameters:
- DEPTH, 4: number of FIFO byte entries; power of two, ≥2.
- TIMEOUT, 255: number of CLK cycles to wait for the high nibble after a low nibble is captured; 1..255.
- SYNC_STAGES, 2: synchroniser flops on STB and D_IN; ≥2.

Ports:
- CLK  in  1  single clock for all state.
- RST  in  1  reset; asynchronous, active-low.
- D_IN  in  4  nibble from the host pins.
- STB  in  1  host strobe; asynchronous; a rising edge means D_IN holds a nibble.
- DATA_OUT  out  8  FIFO head byte; valid only while VALID=1.
- VALID  out  1  FIFO is non-empty.
- RD  in  1  pop request; acted on only when VALID=1.
- OVF  out  1  sticky flag: a byte was dropped because the FIFO was full.
- TERR  out  1  sticky flag: a low nibble was discarded by timeout.
- CLR_ERR  in  1  clears OVF and TERR.

## Operation
- Synchroniser:
  - STB and D_IN each pass through SYNC_STAGES flops.
  - A one-flop history of the synced STB feeds a rising-edge detector (stb_rise).
- Nibble FSM, two states:
  - LO_WAIT (reset state): on stb_rise, latch synced D_IN as the low nibble, load the timeout counter with TIMEOUT, go to HI_WAIT.
  - HI_WAIT on stb_rise: form byte {synced D_IN, low nibble} and push it into the FIFO; go to LO_WAIT.
  - HI_WAIT with no stb_rise: decrement the counter. When the counter reaches 0, discard the low nibble, set TERR, go to LO_WAIT.
  - stb_rise in the same cycle as expiry: TERR is set, the old low nibble is discarded, and the new nibble becomes the low nibble; stay in HI_WAIT and reload the counter.
- FIFO:
  - DEPTH entries; read/write pointers with an extra wrap bit; full when the pointers are equal except the MSB.
  - RD with VALID=1 pops; RD with VALID=0 is ignored.
  - Push while full without a pop: the byte is dropped, OVF is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur and OVF is not set.
  - Push and pop in the same cycle while holding 1 entry: the count stays at 1, the new byte becomes the head, and VALID stays 1.
- Flags: CLR_ERR clears OVF and TERR. If a flag's set condition occurs in the same cycle as CLR_ERR, the set wins.
- Reset (asynchronous, at any time, including mid-byte):
  - FSM goes to LO_WAIT; a pending low nibble is lost.
  - FIFO is emptied and the counter cleared.
  - Synchroniser and edge history are cleared to 0.
  - Outputs: DATA_OUT=0x00, VALID=0, OVF=0, TERR=0.

## Timing
- Host requirements:
  - D_IN stable from 1 CLK cycle before the STB rise until SYNC_STAGES+1 CLK cycles after it.
  - STB high for ≥SYNC_STAGES+1 cycles and low for ≥SYNC_STAGES+1 cycles.
- With SYNC_STAGES=2, the nibble is captured on the 3rd rising CLK edge after the STB rise.
- Push latency: VALID and DATA_OUT update on the edge after the high-nibble capture, i.e. 4 edges after the second STB rise.
- Pop: the registered pop takes effect at the next edge; the following entry appears on DATA_OUT in that same update (first-word fall-through, no bubble).
- Timeout: TERR rises TIMEOUT+1 edges after the low-nibble capture edge if no second stb_rise has occurred.
- All outputs are registered.

## Structure
- Package nibble_rx_pkg:
  - FSM state typedef (LO_WAIT, HI_WAIT).
  - Default DEPTH and TIMEOUT constants.
  - Counter width (8).
- Sub-module byte_fifo:
  - Parameterised by DEPTH and WIDTH=8.
  - Ports: push, din, pop, dout, empty, full.
- The top-level holds the synchroniser, edge detector, FSM, timeout counter and flags.

## Test plan
- Reset values: assert RST low mid-byte (FSM in HI_WAIT, FIFO holding 2 bytes) → DATA_OUT=0x00, VALID=0, OVF=0, TERR=0. After release, strobe 0x5 then 0xA → single byte 0xA5.
- Basic byte: strobe 0x3 then 0xC with RD=0 → VALID rises 4 edges after the second STB rise with DATA_OUT=0xC3. One RD pulse → VALID=0.
- Ordering and wraparound: push 10 bytes 0x00..0x09 while popping, so occupancy stays ≤3 → bytes read out in exact order across pointer wraparound; OVF stays 0.
- Overflow: push DEPTH+1 bytes with RD=0 → FIFO holds the first 4 bytes; OVF=1.
  - Then pop once while pushing a byte → the push is accepted.
  - Then CLR_ERR → OVF=0.
- Timeout: TIMEOUT=8; strobe 0x7 and wait → TERR=1 at capture+9 edges. Next strobes 0x1, 0x2 → byte 0x21.
- Simultaneous events: stb_rise on the exact expiry cycle → TERR=1 and the new nibble is the low nibble. Separately, CLR_ERR coincident with an overflow → OVF stays 1.
